aes_inv_cipher_iter: RTL and testbench

Iterative AES-128 inverse cipher. It accepts one 128-bit ciphertext block over a valid/ready handshake and runs one decryption round per clock. Each round applies InvShiftRows (the inverse of the existing shiftRows), InvSubBytes, AddRoundKey and InvMixColumns. The block returns the plaintext over a second valid/ready handshake. It sits opposite the encrypt datapath and fetches round keys from the expanded-key store by index.

---
 rtl/aes_inv_cipher_iter.sv | 179 +++++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one decryption round per clock, round keys fetched by index.
// Optional macro AES_INV_EARLY_ACCEPT_EN lets a new block be accepted in the DONE handshake cycle.

module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] m);
    logic [7:0] p, s;
    p = 8'h00;
    s = x;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ s;
      s = xt(s);
    end
    return p;
  endfunction

  // x^254 is the field inverse (0 maps to 0)
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r, s;
    r = 8'h01;
    s = x;
    for (int i = 0; i < 7; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  logic [7:0] t;
  assign t = {a[1:0], a[7:2]} ^ {a[4:0], a[7:5]} ^ {a[6:0], a[7]} ^ 8'h05;
  assign y = ginv(t);
endmodule

module aes_inv_mixcol (
  input  logic [3:0][7:0] a,
  output logic [3:0][7:0] b
);
  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  logic [3:0][7:0] m2, m4, m8, m9, mb, md, me;
  for (genvar i = 0; i < 4; i++) begin : g_mul
    assign m2[i] = xt(a[i]);
    assign m4[i] = xt(m2[i]);
    assign m8[i] = xt(m4[i]);
    assign m9[i] = m8[i] ^ a[i];
    assign mb[i] = m8[i] ^ m2[i] ^ a[i];
    assign md[i] = m8[i] ^ m4[i] ^ a[i];
    assign me[i] = m8[i] ^ m4[i] ^ m2[i];
  end

  assign b[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
  assign b[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
  assign b[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
  assign b[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
endmodule

module aes_inv_cipher_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int NB = 16;
  localparam int NC = 4;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        rnd, rnd_nxt;
  logic [NB-1:0][7:0] st, st_nxt, sr, sb, ark, mc;
  logic [127:0]      od_nxt;
  logic              ov_nxt;
  logic              acc;

  // InvShiftRows: row r rotates right by r columns
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NC; c++) begin : g_col
      assign sr[r+4*c] = st[r+4*((c-r+4)%4)];
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_sb
    aes_inv_sbox u_sb (.a(sr[i]), .y(sb[i]));
  end

  // ROUND and FINAL share one S-box bank; only FINAL skips InvMixColumns
  assign ark = sb ^ rk;

  for (genvar c = 0; c < NC; c++) begin : g_mc
    aes_inv_mixcol u_mc (.a(ark[4*c+3:4*c]), .b(mc[4*c+3:4*c]));
  end

`ifdef AES_INV_EARLY_ACCEPT_EN
  assign in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
`else
  assign in_ready = !rst && (state == IDLE);
`endif

  assign acc  = in_valid && in_ready;
  assign busy = (state == ROUND) || (state == FINAL);

  always_comb begin
    case (state)
      ROUND:   rk_idx = rnd;
      FINAL:   rk_idx = 4'd0;
      default: rk_idx = 4'd10;
    endcase
  end

  always_comb begin
    state_nxt = state;
    rnd_nxt   = rnd;
    st_nxt    = st;
    od_nxt    = out_data;
    ov_nxt    = out_valid;
    case (state)
      IDLE: begin
        if (acc) begin
          st_nxt    = in_data ^ rk;
          rnd_nxt   = 4'd9;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        st_nxt = mc;
        if (rnd == 4'd1) state_nxt = FINAL;
        else             rnd_nxt   = rnd - 4'd1;
      end
      FINAL: begin
        od_nxt    = ark;
        ov_nxt    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          ov_nxt    = 1'b0;
          state_nxt = IDLE;
          if (acc) begin
            st_nxt    = in_data ^ rk;
            rnd_nxt   = 4'd9;
            state_nxt = ROUND;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rnd       <= 4'd0;
      st        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      rnd       <= rnd_nxt;
      st        <= st_nxt;
      out_data  <= od_nxt;
      out_valid <= ov_nxt;
    end
  end
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: FIPS-197 vector, table of vectors, handshake/reset corner sequences.
module tb_aes_inv_cipher_iter;
  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data, rk, out_data;
  logic [3:0]   rk_idx;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic         zk;
  logic [127:0] ks [11];
  logic [127:0] cur_exp;
  logic [127:0] exp_q [$];
  int           acc_q [$];
  logic [7:0]   isb [256];
  logic [7:0]   fsb_t [256];

  aes_inv_cipher_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rk_idx(rk_idx), .rk(rk), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    rk = '0;
    if (!zk && rk_idx <= 4'd10) rk = ks[rk_idx];
  end

  // ---------- reference model ----------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] fsb_calc(input logic [7:0] x);
    logic [7:0] v, c;
    v = 0;
    for (int i = 1; i < 256; i++) begin
      c = i[7:0];
      if (x != 0 && gm(x, c) == 8'h01) v = c;
    end
    return v ^ {v[3:0], v[7:4]} ^ {v[4:0], v[7:5]} ^ {v[5:0], v[7:6]} ^ {v[6:0], v[7]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] bswap(input logic [127:0] h);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = h[8*(15-i) +: 8];
    return o;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[7:0], t[31:8]};
        for (int j = 0; j < 4; j++) t[8*j +: 8] = fsb_t[t[8*j +: 8]];
        t[7:0] ^= rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
  endtask

  function automatic logic [127:0] isr_isb(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(r+4*c) +: 8] = isb[s[8*(r+4*((c-r+4)%4)) +: 8]];
    return o;
  endfunction

  function automatic logic [127:0] imix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8]; a1 = s[32*c+8 +: 8]; a2 = s[32*c+16 +: 8]; a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
      o[32*c+8 +: 8]  = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
      o[32*c+16 +: 8] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
      o[32*c+24 +: 8] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [127:0] mdec(input logic [127:0] ct, input logic z);
    logic [127:0] s, k [11];
    for (int r = 0; r < 11; r++) k[r] = z ? 128'h0 : ks[r];
    s = ct ^ k[10];
    for (int r = 9; r >= 1; r--) s = imix(isr_isb(s) ^ k[r]);
    return isr_isb(s) ^ k[0];
  endfunction

  // ---------- checking ----------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", out_data, 128'hx);
        else chk("sb_out_data", out_data, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        acc_q.push_back(cyc);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int maxc);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < maxc && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic send(input logic [127:0] ct, input logic [127:0] e);
    in_data  = ct;
    cur_exp  = e;
    in_valid = 1'b1;
    wait_acc(40);
  endtask

  task automatic wait_empty(input int maxc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) chk("output_timeout", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [127:0] ct;
    logic         z;
    logic [127:0] pt;
  } vec_t;

  vec_t vt [4];
  logic [127:0] fkey, fct, fpt, ct2, e2;
  int gap;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; zk = 1'b0; cur_exp = '0;
    for (int x = 0; x < 256; x++) fsb_t[x] = fsb_calc(x[7:0]);
    for (int x = 0; x < 256; x++) isb[fsb_t[x]] = x[7:0];
    fkey = bswap(128'h000102030405060708090a0b0c0d0e0f);
    fct  = bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    fpt  = bswap(128'h00112233445566778899aabbccddeeff);
    expand(fkey);

    vt[0] = '{fct, 1'b0, fpt};
    vt[1] = '{128'h0, 1'b1, mdec(128'h0, 1'b1)};
    vt[2] = '{128'h0123456789abcdeffedcba9876543210, 1'b0, mdec(128'h0123456789abcdeffedcba9876543210, 1'b0)};
    vt[3] = '{{128{1'b1}}, 1'b1, mdec({128{1'b1}}, 1'b1)};

    // reset
    repeat (3) tick();
    @(negedge clk);
    chk("in_ready_in_rst", in_ready, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rk_idx", rk_idx, 10);
    chk("rst_in_ready", in_ready, 1);

    // FIPS vector with per-cycle rk_idx / busy / out_valid trace
    tick();
    in_data = fct; cur_exp = fpt; in_valid = 1'b1;
    @(negedge clk);
    chk("acc_in_ready", in_ready, 1);
    chk("trace_rk_idx_0", rk_idx, 10);
    chk("trace_busy_0", busy, 0);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      chk($sformatf("trace_rk_idx_%0d", k), rk_idx, (k <= 10) ? 10 - k : 10);
      chk($sformatf("trace_busy_%0d", k), busy, k <= 10);
      chk($sformatf("trace_out_valid_%0d", k), out_valid, k == 11);
      tick();
    end
    chk("fips_out_data", out_data, fpt);

    // backpressure with a second block waiting
    ct2 = vt[2].ct; e2 = vt[2].pt;
    in_data = ct2; cur_exp = e2; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, fpt);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    wait_acc(5);
    wait_empty(30);

    // table-driven vectors
    for (int v = 0; v < 4; v++) begin
      zk = vt[v].z;
      send(vt[v].ct, vt[v].pt);
      wait_empty(30);
    end
    zk = 1'b0;

    // back-to-back throughput
    acc_q.delete();
    send(fct, fpt);
    send(vt[2].ct, vt[2].pt);
    wait_empty(40);
    gap = (acc_q.size() == 2) ? acc_q[1] - acc_q[0] : -1;
`ifdef AES_INV_EARLY_ACCEPT_EN
    chk("b2b_gap", gap, 11);
`else
    chk("b2b_gap", gap, 12);
`endif

    // reset mid-round
    send(fct, fpt);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rk_idx", rk_idx, 10);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_queue", exp_q.size(), 0);
    repeat (15) tick();
    chk("abort_no_output", out_valid, 0);
    send(fct, fpt);
    wait_empty(30);

    repeat (3) tick();
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
